// File: rtl/multi_counter.sv
// Bank of NCH independent modulo-BOUND counters with up/down, load, flush, wrap or saturate.
// Define MULTI_COUNTER_CARRY_EN to cascade channels into a multi-digit counter.
module multi_counter #(
    parameter int BOUND    = 1,
    parameter int NCH      = 1,
    parameter int WIDTH    = (BOUND == 1) ? 1 : $clog2(BOUND),
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       i_tick,
    input  logic [NCH-1:0]       i_dir,
    input  logic [NCH-1:0]       i_load,
    input  logic [NCH*WIDTH-1:0] i_load_val,
    input  logic [NCH-1:0]       i_flush,
    output logic [NCH*WIDTH-1:0] o_current,
    output logic [NCH-1:0]       o_wrap,
    output logic [NCH-1:0]       o_at_end
);

    localparam logic             SAT  = (SATURATE != 0);
    localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(BOUND - 1);
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAXC = MAXV[WIDTH-1:0];

    logic [NCH-1:0] w_eff_tick;

`ifdef MULTI_COUNTER_CARRY_EN
    // Carry ripples combinationally so a full digit roll-over completes in one edge.
    always_comb begin
        logic v_carry;
        v_carry    = 1'b0;
        w_eff_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            w_eff_tick[i] = i_tick[i] | v_carry;
            v_carry = w_eff_tick[i] & o_at_end[i] & ~i_flush[i] & ~i_load[i] & ~SAT;
        end
    end
`else
    assign w_eff_tick = i_tick;
`endif

    if (BOUND == 1) begin : g_trivial
        logic           w_unused;
        logic [NCH-1:0] r_wrap;

        assign w_unused  = ^{i_load_val, i_dir};
        assign o_current = '0;
        assign o_at_end  = '1;
        assign o_wrap    = r_wrap;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wrap <= '0;
            end else if (SAT) begin
                r_wrap <= '0;
            end else begin
                r_wrap <= w_eff_tick & ~i_flush & ~i_load;
            end
        end
    end else begin : g_count
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            logic [WIDTH-1:0] r_cur;
            logic             r_wrap;
            logic [WIDTH:0]   w_inc;
            logic [WIDTH:0]   w_dec;
            logic [WIDTH:0]   w_lv;

            assign w_inc = {1'b0, r_cur} + ONE;
            assign w_dec = {1'b0, r_cur} - ONE;
            assign w_lv  = {1'b0, i_load_val[g*WIDTH +: WIDTH]};

            assign o_current[g*WIDTH +: WIDTH] = r_cur;
            assign o_wrap[g]   = r_wrap;
            assign o_at_end[g] = i_dir[g] ? (r_cur == '0) : (r_cur == MAXC);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cur  <= '0;
                    r_wrap <= 1'b0;
                end else if (i_flush[g]) begin
                    r_cur  <= '0;
                    r_wrap <= 1'b0;
                end else if (i_load[g]) begin
                    r_cur  <= (w_lv > MAXV) ? MAXC : w_lv[WIDTH-1:0];
                    r_wrap <= 1'b0;
                end else if (w_eff_tick[g]) begin
                    if (!i_dir[g]) begin
                        if (r_cur == MAXC) begin
                            r_cur  <= SAT ? r_cur : '0;
                            r_wrap <= ~SAT;
                        end else begin
                            r_cur  <= w_inc[WIDTH-1:0];
                            r_wrap <= SAT && (w_inc == MAXV);
                        end
                    end else begin
                        if (r_cur == '0) begin
                            r_cur  <= SAT ? r_cur : MAXC;
                            r_wrap <= ~SAT;
                        end else begin
                            r_cur  <= w_dec[WIDTH-1:0];
                            r_wrap <= SAT && (w_dec == '0);
                        end
                    end
                end else begin
                    r_wrap <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: several instances covering wrap, down, priority,
// saturate, BOUND=1 and the multi-channel (optionally carry-chained) bank.
module tb_multi_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // BOUND=5 wrap
    logic       tick5 = 0, dir5 = 0, load5 = 0, flush5 = 0;
    logic [2:0] lv5 = '0, cur5;
    logic       wrap5, ae5;
    // BOUND=6 wrap
    logic       tick6 = 0, dir6 = 0, load6 = 0, flush6 = 0;
    logic [2:0] lv6 = '0, cur6;
    logic       wrap6, ae6;
    // BOUND=4 saturate
    logic       tick4 = 0, dir4 = 0, load4 = 0, flush4 = 0;
    logic [1:0] lv4 = '0, cur4;
    logic       wrap4, ae4;
    // BOUND=1
    logic       tick1 = 0, dir1 = 0, load1 = 0, flush1 = 0;
    logic [0:0] lv1 = '0, cur1;
    logic       wrap1, ae1;
    // BOUND=10, NCH=3
    logic [2:0]  tick10 = '0, dir10 = '0, load10 = '0, flush10 = '0;
    logic [11:0] lv10 = '0, cur10;
    logic [2:0]  wrap10, ae10;

    multi_counter #(.BOUND(5), .NCH(1)) u5 (
        .clk(clk), .rst(rst), .i_tick(tick5), .i_dir(dir5), .i_load(load5),
        .i_load_val(lv5), .i_flush(flush5), .o_current(cur5), .o_wrap(wrap5), .o_at_end(ae5));
    multi_counter #(.BOUND(6), .NCH(1)) u6 (
        .clk(clk), .rst(rst), .i_tick(tick6), .i_dir(dir6), .i_load(load6),
        .i_load_val(lv6), .i_flush(flush6), .o_current(cur6), .o_wrap(wrap6), .o_at_end(ae6));
    multi_counter #(.BOUND(4), .NCH(1), .SATURATE(1)) u4s (
        .clk(clk), .rst(rst), .i_tick(tick4), .i_dir(dir4), .i_load(load4),
        .i_load_val(lv4), .i_flush(flush4), .o_current(cur4), .o_wrap(wrap4), .o_at_end(ae4));
    multi_counter #(.BOUND(1), .NCH(1)) u1 (
        .clk(clk), .rst(rst), .i_tick(tick1), .i_dir(dir1), .i_load(load1),
        .i_load_val(lv1), .i_flush(flush1), .o_current(cur1), .o_wrap(wrap1), .o_at_end(ae1));
    multi_counter #(.BOUND(10), .NCH(3)) u10 (
        .clk(clk), .rst(rst), .i_tick(tick10), .i_dir(dir10), .i_load(load10),
        .i_load_val(lv10), .i_flush(flush10), .o_current(cur10), .o_wrap(wrap10), .o_at_end(ae10));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         exp5[6] = '{1, 2, 3, 4, 0, 1};
        int         exp6[4] = '{1, 0, 5, 4};
        int         exp4[5] = '{1, 2, 3, 3, 3};
        int         exp4d[4] = '{2, 1, 0, 0};
        logic [4:0] pat1 = 5'b01101;

        // Reset state
        #2;
        chk("rst_cur5", 32'(cur5), 0);
        chk("rst_wrap5", 32'(wrap5), 0);
        chk("rst_ae5", 32'(ae5), 0);
        chk("rst_cur10", 32'(cur10), 0);
        chk("rst_wrap10", 32'(wrap10), 0);
        chk("rst_ae10", 32'(ae10), 0);
        chk("rst_ae1", 32'(ae1), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic wrap, BOUND=5
        tick5 = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("up5_cur_%0d", k), 32'(cur5), 32'(exp5[k]));
            chk($sformatf("up5_wrap_%0d", k), 32'(wrap5), (k == 4) ? 1 : 0);
            chk($sformatf("up5_ae_%0d", k), 32'(ae5), (k == 3) ? 1 : 0);
        end
        step();
        chk("up5_cur_pre_rst", 32'(cur5), 2);
        rst = 1;
        #1;
        chk("midrst_cur5", 32'(cur5), 0);
        chk("midrst_wrap5", 32'(wrap5), 0);
        rst = 0;
        step();
        chk("postrst_cur5", 32'(cur5), 1);
        tick5 = 0;

        // Down count, BOUND=6
        load6 = 1; lv6 = 3'd2;
        step();
        chk("ld6_cur", 32'(cur6), 2);
        load6 = 0; dir6 = 1; tick6 = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("dn6_cur_%0d", k), 32'(cur6), 32'(exp6[k]));
            chk($sformatf("dn6_wrap_%0d", k), 32'(wrap6), (k == 2) ? 1 : 0);
            chk($sformatf("dn6_ae_%0d", k), 32'(ae6), (k == 1) ? 1 : 0);
        end
        tick6 = 0;
        step();
        chk("hold6_cur", 32'(cur6), 4);
        chk("hold6_wrap", 32'(wrap6), 0);
        load6 = 1; lv6 = 3'd7;
        step();
        chk("ldclamp6_cur", 32'(cur6), 5);
        load6 = 0;

        // Priority, BOUND=5
        load5 = 1; lv5 = 3'd3;
        step();
        chk("pri_setup_cur", 32'(cur5), 3);
        flush5 = 1; load5 = 1; lv5 = 3'd1; tick5 = 1;
        step();
        chk("pri_flush_cur", 32'(cur5), 0);
        chk("pri_flush_wrap", 32'(wrap5), 0);
        flush5 = 0; load5 = 1; lv5 = 3'd7; tick5 = 1;
        step();
        chk("pri_load_cur", 32'(cur5), 4);
        chk("pri_load_wrap", 32'(wrap5), 0);
        load5 = 0; flush5 = 1; tick5 = 1;
        step();
        chk("pri_flushend_cur", 32'(cur5), 0);
        chk("pri_flushend_wrap", 32'(wrap5), 0);
        flush5 = 0; tick5 = 0;

        // Saturate, BOUND=4
        tick4 = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("sat_up_cur_%0d", k), 32'(cur4), 32'(exp4[k]));
            chk($sformatf("sat_up_wrap_%0d", k), 32'(wrap4), (k == 2) ? 1 : 0);
            chk($sformatf("sat_up_ae_%0d", k), 32'(ae4), (k >= 2) ? 1 : 0);
        end
        dir4 = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("sat_dn_cur_%0d", k), 32'(cur4), 32'(exp4d[k]));
            chk($sformatf("sat_dn_wrap_%0d", k), 32'(wrap4), (k == 2) ? 1 : 0);
        end
        tick4 = 0;

        // BOUND=1
        for (int k = 0; k < 5; k++) begin
            tick1 = pat1[k];
            step();
            chk($sformatf("b1_wrap_%0d", k), 32'(wrap1), 32'(pat1[k]));
            chk($sformatf("b1_cur_%0d", k), 32'(cur1), 0);
            chk($sformatf("b1_ae_%0d", k), 32'(ae1), 1);
        end
        tick1 = 0;

        // Three-channel bank, BOUND=10
        load10 = 3'b111; lv10 = 12'h999;
        step();
        chk("bank_ld_cur", 32'(cur10), 32'h999);
        chk("bank_ld_ae", 32'(ae10), 3'b111);
        load10 = 3'b000; tick10 = 3'b001;
        step();
`ifdef MULTI_COUNTER_CARRY_EN
        chk("bank_carry_cur", 32'(cur10), 32'h000);
        chk("bank_carry_wrap", 32'(wrap10), 3'b111);
`else
        chk("bank_carry_cur", 32'(cur10), 32'h990);
        chk("bank_carry_wrap", 32'(wrap10), 3'b001);
`endif
        tick10 = 3'b000; load10 = 3'b111; lv10 = 12'h999;
        step();
        chk("bank_reld_cur", 32'(cur10), 32'h999);
        load10 = 3'b000; tick10 = 3'b001; flush10 = 3'b010;
        step();
        chk("bank_flush_cur", 32'(cur10), 32'h900);
        chk("bank_flush_wrap", 32'(wrap10), 3'b001);
        flush10 = 3'b000; tick10 = 3'b000; load10 = 3'b111; lv10 = 12'h039;
        step();
        chk("bank_ld2_cur", 32'(cur10), 32'h039);
        load10 = 3'b000; tick10 = 3'b011;
        step();
        chk("bank_dbl_cur", 32'(cur10), 32'h040);
        chk("bank_dbl_wrap", 32'(wrap10), 3'b001);
        tick10 = 3'b100; dir10 = 3'b100;
        step();
        chk("bank_dn2_cur", 32'(cur10), 32'h940);
        chk("bank_dn2_wrap", 32'(wrap10), 3'b100);
        tick10 = 3'b000;
        step();
        chk("bank_idle_wrap", 32'(wrap10), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
